// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//   ID-stage hazard detection and stall controller for a 5-stage MIPS
//   pipeline. A two-entry shadow pipeline (EX and MEM slots) records the
//   destination register of every in-flight instruction. The block stalls
//   the instruction held in IF/ID when forwarding cannot supply its
//   operands in time:
//     - load-use: a load in EX feeds any source of the ID instruction
//     - a branch in ID depends on any producer in EX (branch operands can
//       only be forwarded from EX/MEM)
//     - a branch in ID depends on a load in MEM
//   A taken branch flushes IF/ID unless the branch itself is stalled.
//   Stall cycles are counted in a saturating counter.
//
// Ports
//   clk           in   pipeline clock
//   reset         in   synchronous, active-high reset
//   id_instru     in   [31:0] instruction held in IF/ID
//   branch_taken  in   ID branch comparator result
//   pc_write      out  1 = PC may update
//   if_id_write   out  1 = IF/ID may load
//   id_ex_bubble  out  1 = ID/EX loads a bubble
//   if_id_flush   out  1 = IF/ID loads NOP at the next edge
//   stall_cycles  out  [CNT_W-1:0] saturating stall-cycle count
// ---------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      id_instru,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef struct packed {
    logic       regwrite;
    logic       memread;
    logic [4:0] dest;
  } slot_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // A producer in a slot matches a register only when that register is
  // actually read by the ID instruction.
  function automatic logic slot_match(input slot_t s, input logic [4:0] r,
                                      input logic used);
    return s.regwrite && (s.dest == r) && used;
  endfunction

  logic [5:0] op_s;
  logic [4:0] rs_s;
  logic [4:0] rt_s;
  logic [4:0] rd_s;
  logic [5:0] funct_s;
  logic       unused_bits_s;

  logic       rs_used_s;
  logic       rt_used_s;
  logic       is_branch_s;
  slot_t      id_slot_s;

  logic       ex_hit_s;
  logic       mem_hit_s;
  logic       hazard_s;
  logic       stall_s;

  slot_t            ex_q,  ex_d;
  slot_t            mem_q, mem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign op_s          = id_instru[31:26];
  assign rs_s          = id_instru[25:21];
  assign rt_s          = id_instru[20:16];
  assign rd_s          = id_instru[15:11];
  assign funct_s       = id_instru[5:0];
  // shamt is irrelevant to hazard detection
  assign unused_bits_s = ^id_instru[10:6];

  // Decode source usage, destination, RegWrite and MemRead of the ID instruction.
  always_comb begin
    rs_used_s          = 1'b1;
    rt_used_s          = 1'b0;
    id_slot_s.regwrite = 1'b0;
    id_slot_s.memread  = (op_s == 6'd35);
    id_slot_s.dest     = 5'd0;

    case (op_s)
      6'd2, 6'd3, 6'd15: rs_used_s = 1'b0;
      default:           rs_used_s = 1'b1;
    endcase

    case (op_s)
      6'd0, 6'd4, 6'd5, 6'd43: rt_used_s = 1'b1;
      default:                 rt_used_s = 1'b0;
    endcase

    case (op_s)
      6'd0: begin
        if (funct_s != 6'd8) begin
          id_slot_s.regwrite = 1'b1;
          id_slot_s.dest     = rd_s;
        end else begin
          // jr writes nothing
          id_slot_s.regwrite = 1'b0;
          id_slot_s.dest     = 5'd0;
        end
      end
      6'd8, 6'd9, 6'd10, 6'd12, 6'd13, 6'd15, 6'd35: begin
        id_slot_s.regwrite = 1'b1;
        id_slot_s.dest     = rt_s;
      end
      6'd3: begin
        id_slot_s.regwrite = 1'b1;
        id_slot_s.dest     = 5'd31;
      end
      default: begin
        id_slot_s.regwrite = 1'b0;
        id_slot_s.dest     = 5'd0;
      end
    endcase

    // $0 is hardwired; writing it is never a dependency
    if (id_slot_s.dest == 5'd0) begin
      id_slot_s.regwrite = 1'b0;
    end else begin
      id_slot_s.regwrite = id_slot_s.regwrite;
    end
  end

  assign is_branch_s = (op_s == 6'd4) || (op_s == 6'd5);

  assign ex_hit_s  = slot_match(ex_q, rs_s, rs_used_s) ||
                     slot_match(ex_q, rt_s, rt_used_s);
  assign mem_hit_s = slot_match(mem_q, rs_s, rs_used_s) ||
                     slot_match(mem_q, rt_s, rt_used_s);

  // Non-load producers in MEM are reachable by forwarding, so only a
  // load in MEM matters, and only for a branch.
  assign hazard_s = (ex_q.memread && ex_hit_s) ||
                    (is_branch_s && ex_hit_s) ||
                    (is_branch_s && mem_q.memread && mem_hit_s);

  assign stall_s = hazard_s && !reset;

  assign pc_write     = !stall_s;
  assign if_id_write  = !stall_s;
  assign id_ex_bubble = stall_s;
  // A stalled branch has stale operands, so its comparator result is ignored.
  assign if_id_flush  = branch_taken && is_branch_s && !stall_s && !reset;
  assign stall_cycles = cnt_q;

  // Next state of the shadow slots and the saturating stall counter.
  always_comb begin
    ex_d  = id_slot_s;
    mem_d = ex_q;
    cnt_d = cnt_q;
    if (reset) begin
      ex_d  = '0;
      mem_d = '0;
      cnt_d = {CNT_W{1'b0}};
    end else begin
      if (stall_s) begin
        ex_d = '0;
      end else begin
        ex_d = id_slot_s;
      end
      if (stall_s && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_ONE;
      end else begin
        cnt_d = cnt_q;
      end
    end
  end

  // State registers; reset is folded into the next-state logic above.
  always_ff @(posedge clk) begin
    ex_q  <= ex_d;
    mem_q <= mem_d;
    cnt_q <= cnt_d;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam logic [31:0] NOP    = 32'h0000_0000;
  localparam logic [31:0] LW2    = 32'h8C22_0000; // lw  $2,0($1)
  localparam logic [31:0] ADD324 = 32'h0044_1820; // add $3,$2,$4
  localparam logic [31:0] BEQ2   = 32'h1040_0003; // beq $2,$0,3
  localparam logic [31:0] ADD211 = 32'h0021_1020; // add $2,$1,$1
  localparam logic [31:0] ADD567 = 32'h00C7_2820; // add $5,$6,$7
  localparam logic [31:0] LW0    = 32'h8C20_0000; // lw  $0,0($1)
  localparam logic [31:0] ADD304 = 32'h0004_1820; // add $3,$0,$4
  localparam logic [31:0] SW2    = 32'hAC22_0000; // sw  $2,0($1)
  localparam logic [31:0] JAL    = 32'h0C00_0000; // jal 0
  localparam logic [31:0] BEQ31  = 32'h13E0_0003; // beq $31,$0,3

  logic        clk;
  logic        reset;
  logic [31:0] id_instru;
  logic        branch_taken;
  logic        pc_write, if_id_write, id_ex_bubble, if_id_flush;
  logic [15:0] stall_cycles;
  logic        s_pc_write, s_if_id_write, s_id_ex_bubble, s_if_id_flush;
  logic [3:0]  s_stall_cycles;

  hazard_ctrl dut (
    .clk(clk), .reset(reset), .id_instru(id_instru), .branch_taken(branch_taken),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_bubble(id_ex_bubble),
    .if_id_flush(if_id_flush), .stall_cycles(stall_cycles)
  );

  // narrow-counter copy so saturation is reachable in a short run
  hazard_ctrl #(.CNT_W(4)) dut_s (
    .clk(clk), .reset(reset), .id_instru(id_instru), .branch_taken(branch_taken),
    .pc_write(s_pc_write), .if_id_write(s_if_id_write), .id_ex_bubble(s_id_ex_bubble),
    .if_id_flush(s_if_id_flush), .stall_cycles(s_stall_cycles)
  );

  typedef struct {
    logic        pcw;
    logic        ifw;
    logic        bub;
    logic        fl;
    logic [15:0] cnt;
    logic [3:0]  cnt_s;
    int          idx;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cnt_model = 0;
  int   step_no = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d actual=%0h required=%0h", name, idx, act, exp);
    end
  endtask

  // monitor: outputs are combinational, so one result per cycle is checked
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("pc_write",       e.idx, {31'd0, pc_write},       {31'd0, e.pcw});
      chk("if_id_write",    e.idx, {31'd0, if_id_write},    {31'd0, e.ifw});
      chk("id_ex_bubble",   e.idx, {31'd0, id_ex_bubble},   {31'd0, e.bub});
      chk("if_id_flush",    e.idx, {31'd0, if_id_flush},    {31'd0, e.fl});
      chk("stall_cycles",   e.idx, {16'd0, stall_cycles},   {16'd0, e.cnt});
      chk("stall_cycles_4", e.idx, {28'd0, s_stall_cycles}, {28'd0, e.cnt_s});
      chk("bubble_4",       e.idx, {31'd0, s_id_ex_bubble}, {31'd0, e.bub});
    end
  end

  // one pipeline cycle of stimulus plus its hand-derived expected outputs
  task automatic step(input logic rst, input logic [31:0] ins, input logic tk,
                      input logic exp_stall, input logic exp_fl);
    exp_t e;
    @(posedge clk);
    #1;
    reset        = rst;
    id_instru    = ins;
    branch_taken = tk;
    step_no++;
    e.pcw   = !exp_stall;
    e.ifw   = !exp_stall;
    e.bub   = exp_stall;
    e.fl    = exp_fl;
    e.cnt   = cnt_model[15:0];
    e.cnt_s = (cnt_model > 15) ? 4'hF : cnt_model[3:0];
    e.idx   = step_no;
    q.push_back(e);
    if (rst) cnt_model = 0;
    else if (exp_stall) cnt_model++;
  endtask

  initial begin
    reset = 1'b1; id_instru = NOP; branch_taken = 1'b0;
    repeat (2) @(posedge clk);

    step(1'b1, ADD324, 1'b1, 1'b0, 1'b0); // reset forces unstalled outputs
    // load-use: exactly one stall
    step(1'b0, LW2,    1'b0, 1'b0, 1'b0);
    step(1'b0, ADD324, 1'b0, 1'b1, 1'b0);
    step(1'b0, ADD324, 1'b0, 1'b0, 1'b0);
    step(1'b0, NOP,    1'b0, 1'b0, 1'b0);
    // lw then beq: two stalls, then taken branch flushes
    step(1'b0, LW2,    1'b0, 1'b0, 1'b0);
    step(1'b0, BEQ2,   1'b0, 1'b1, 1'b0);
    step(1'b0, BEQ2,   1'b0, 1'b1, 1'b0);
    step(1'b0, BEQ2,   1'b1, 1'b0, 1'b1);
    step(1'b0, NOP,    1'b0, 1'b0, 1'b0);
    // ALU producer then beq: one stall
    step(1'b0, ADD211, 1'b0, 1'b0, 1'b0);
    step(1'b0, BEQ2,   1'b0, 1'b1, 1'b0);
    step(1'b0, BEQ2,   1'b0, 1'b0, 1'b0);
    // independent instruction between: no stall
    step(1'b0, ADD211, 1'b0, 1'b0, 1'b0);
    step(1'b0, ADD567, 1'b0, 1'b0, 1'b0);
    step(1'b0, BEQ2,   1'b0, 1'b0, 1'b0);
    step(1'b0, NOP,    1'b0, 1'b0, 1'b0);
    // load into $0: no dependency
    step(1'b0, LW0,    1'b0, 1'b0, 1'b0);
    step(1'b0, ADD304, 1'b0, 1'b0, 1'b0);
    step(1'b0, NOP,    1'b0, 1'b0, 1'b0);
    // store reads rt: one stall
    step(1'b0, LW2,    1'b0, 1'b0, 1'b0);
    step(1'b0, SW2,    1'b0, 1'b1, 1'b0);
    step(1'b0, SW2,    1'b0, 1'b0, 1'b0);
    step(1'b0, NOP,    1'b0, 1'b0, 1'b0);
    // taken branch ignored while stalled
    step(1'b0, LW2,    1'b0, 1'b0, 1'b0);
    step(1'b0, BEQ2,   1'b1, 1'b1, 1'b0);
    step(1'b0, BEQ2,   1'b1, 1'b1, 1'b0);
    step(1'b0, BEQ2,   1'b1, 1'b0, 1'b1);
    step(1'b0, NOP,    1'b0, 1'b0, 1'b0);
    // jal writes $31
    step(1'b0, JAL,    1'b0, 1'b0, 1'b0);
    step(1'b0, BEQ31,  1'b0, 1'b1, 1'b0);
    step(1'b0, BEQ31,  1'b0, 1'b0, 1'b0);
    step(1'b0, NOP,    1'b0, 1'b0, 1'b0);
    // reset during first cycle of a lw-beq double stall
    step(1'b0, LW2,    1'b0, 1'b0, 1'b0);
    step(1'b1, BEQ2,   1'b1, 1'b0, 1'b0);
    step(1'b0, BEQ2,   1'b0, 1'b0, 1'b0);
    step(1'b0, NOP,    1'b0, 1'b0, 1'b0);
    // 20 stalls: narrow counter must hold at all-ones, wide one keeps counting
    for (int k = 0; k < 10; k++) begin
      step(1'b0, LW2,  1'b0, 1'b0, 1'b0);
      step(1'b0, BEQ2, 1'b0, 1'b1, 1'b0);
      step(1'b0, BEQ2, 1'b0, 1'b1, 1'b0);
      step(1'b0, BEQ2, 1'b0, 1'b0, 1'b0);
    end
    step(1'b0, NOP,    1'b0, 1'b0, 1'b0);
    step(1'b0, NOP,    1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
